// File: rtl/picorv_hpdc_bridge.sv
// -----------------------------------------------------------------------------
// picorv_hpdc_bridge
//
// Bridges up to four picorv32-style native memory ports onto one cache
// request/response channel. Each core has a small FSM (IDLE/PEND/WAIT/DONE).
// A round-robin arbiter picks one pending core per cycle into a registered
// request slot. Responses are matched back by {sid, tid}. A per-core watchdog
// completes a core with an error word if its response never arrives.
//
// Ports
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   cpu_valid_i/addr/wdata/wstrb   per-core native request (core k in slice k)
//   cpu_ready_o/cpu_rdata_o        per-core one-cycle completion + read data
//   req_*                          registered cache request channel
//   rsp_*                          cache response channel
//   err_timeout_o/err_bus_o        per-core sticky error flags
//   err_unexpected_o               sticky flag for dropped responses
// -----------------------------------------------------------------------------
module picorv_hpdc_bridge #(
    parameter int unsigned NumCores      = 2,
    parameter logic [31:0] PhysMemLimit  = 32'h0002_0000,
    parameter int unsigned TidWidth      = 4,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumCores-1:0]    cpu_valid_i,
    input  logic [32*NumCores-1:0] cpu_addr_i,
    input  logic [32*NumCores-1:0] cpu_wdata_i,
    input  logic [4*NumCores-1:0]  cpu_wstrb_i,
    output logic [NumCores-1:0]    cpu_ready_o,
    output logic [32*NumCores-1:0] cpu_rdata_o,
    output logic                   req_valid_o,
    input  logic                   req_ready_i,
    output logic [31:0]            req_addr_o,
    output logic [31:0]            req_wdata_o,
    output logic [3:0]             req_be_o,
    output logic                   req_store_o,
    output logic                   req_uncacheable_o,
    output logic [1:0]             req_sid_o,
    output logic [TidWidth-1:0]    req_tid_o,
    input  logic                   rsp_valid_i,
    input  logic [1:0]             rsp_sid_i,
    input  logic [TidWidth-1:0]    rsp_tid_i,
    input  logic [31:0]            rsp_rdata_i,
    input  logic                   rsp_error_i,
    output logic [NumCores-1:0]    err_timeout_o,
    output logic                   err_unexpected_o,
    output logic [NumCores-1:0]    err_bus_o
);

    localparam int unsigned         CntWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntWidth-1:0] CntLast  = CntWidth'(TimeoutCycles - 1);
    localparam logic [CntWidth-1:0] CntOne   = CntWidth'(1);
    localparam logic [TidWidth-1:0] TidOne   = TidWidth'(1);
    localparam logic [31:0]         ErrData  = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {S_IDLE, S_PEND, S_WAIT, S_DONE} state_e;

    typedef struct packed {
        logic [31:0]         addr;
        logic [31:0]         wdata;
        logic [3:0]          be;
        logic                store;
        logic                uncacheable;
        logic [1:0]          sid;
        logic [TidWidth-1:0] tid;
    } req_t;

    // Per-core state
    state_e              state_q [NumCores];
    state_e              state_d [NumCores];
    logic [31:0]         addr_q  [NumCores];
    logic [31:0]         wdata_q [NumCores];
    logic [3:0]          wstrb_q [NumCores];
    logic [TidWidth-1:0] tid_q   [NumCores];
    logic [TidWidth-1:0] tid_d   [NumCores];
    logic [CntWidth-1:0] cnt_q   [NumCores];
    logic [CntWidth-1:0] cnt_d   [NumCores];
    logic [31:0]         rdata_q [NumCores];
    logic [31:0]         rdata_d [NumCores];

    // Shared request slot, arbiter and flags
    logic                req_valid_q, req_valid_d;
    req_t                req_q, req_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [1:0]          grant_idx, cand;
    logic                grant_valid;
    logic [3:0]          eligible;
    logic [NumCores-1:0] match, tout_set, bus_set;
    logic                accept, can_issue, unexpected;
    logic [NumCores-1:0] err_timeout_q, err_bus_q;
    logic                err_unexpected_q;

    assign accept     = req_valid_q && req_ready_i;
    // The slot may be refilled when empty or when its content leaves this cycle.
    assign can_issue  = !req_valid_q || req_ready_i;
    assign unexpected = rsp_valid_i && !(|match);

    // Response matching and arbitration eligibility. A core whose request is
    // already sitting in the slot stays PEND but must not be granted again.
    always_comb begin
        match    = '0;
        eligible = '0;
        for (int k = 0; k < NumCores; k++) begin
            // tid_q already advanced at issue, so the outstanding tid is tid_q-1.
            match[k]    = rsp_valid_i && (rsp_sid_i == 2'(k)) && (state_q[k] == S_WAIT)
                          && (rsp_tid_i == tid_q[k] - TidOne);
            eligible[k] = (state_q[k] == S_PEND) && !(req_valid_q && (req_q.sid == 2'(k)));
        end
    end

    // Round-robin: ptr_q is the first core to consider, i.e. one past the last grant.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NumCores; i++) begin
            cand = 2'((int'(ptr_q) + i) % NumCores);
            if (!grant_valid && eligible[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
        ptr_d = ptr_q;
        if (grant_valid && can_issue) begin
            ptr_d = (grant_idx == 2'(NumCores - 1)) ? 2'd0 : grant_idx + 2'd1;
        end
    end

    // Per-core FSM next state and request slot next state.
    always_comb begin
        req_valid_d = req_valid_q;
        req_d       = req_q;
        tout_set    = '0;
        bus_set     = '0;
        if (can_issue) begin
            req_valid_d = grant_valid;
        end
        for (int k = 0; k < NumCores; k++) begin
            state_d[k] = state_q[k];
            tid_d[k]   = tid_q[k];
            cnt_d[k]   = cnt_q[k];
            rdata_d[k] = rdata_q[k];

            if (can_issue && grant_valid && (grant_idx == 2'(k))) begin
                req_d.addr        = addr_q[k];
                req_d.wdata       = wdata_q[k];
                req_d.store       = |wstrb_q[k];
                req_d.be          = (|wstrb_q[k]) ? wstrb_q[k] : 4'hF;
                req_d.uncacheable = (addr_q[k] >= PhysMemLimit);
                req_d.sid         = 2'(k);
                req_d.tid         = tid_q[k];
            end

            unique case (state_q[k])
                S_IDLE: begin
                    if (cpu_valid_i[k]) state_d[k] = S_PEND;
                end
                S_PEND: begin
                    if (accept && (req_q.sid == 2'(k))) begin
                        state_d[k] = S_WAIT;
                        cnt_d[k]   = '0;
                        tid_d[k]   = tid_q[k] + TidOne;
                    end
                end
                S_WAIT: begin
                    // A matching response beats a timeout expiring in the same cycle.
                    if (match[k]) begin
                        state_d[k] = S_DONE;
                        bus_set[k] = rsp_error_i;
                        if (rsp_error_i)       rdata_d[k] = ErrData;
                        else if (|wstrb_q[k])  rdata_d[k] = '0;
                        else                   rdata_d[k] = rsp_rdata_i;
                    end else if (cnt_q[k] == CntLast) begin
                        state_d[k]  = S_DONE;
                        tout_set[k] = 1'b1;
                        rdata_d[k]  = ErrData;
                    end else begin
                        cnt_d[k] = cnt_q[k] + CntOne;
                    end
                end
                S_DONE: begin
                    state_d[k] = S_IDLE;
                end
                default: state_d[k] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the per-core register arrays are small flop banks that feed
            // outputs and match logic, so they are reset like any other flop
            // rather than treated as an unreset RAM.
            for (int k = 0; k < NumCores; k++) begin
                state_q[k] <= S_IDLE;
                addr_q[k]  <= '0;
                wdata_q[k] <= '0;
                wstrb_q[k] <= '0;
                tid_q[k]   <= '0;
                cnt_q[k]   <= '0;
                rdata_q[k] <= '0;
            end
            req_valid_q      <= 1'b0;
            req_q            <= '0;
            ptr_q            <= '0;
            err_timeout_q    <= '0;
            err_bus_q        <= '0;
            err_unexpected_q <= 1'b0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every flop
            // samples the pre-edge values, independent of statement order.
            for (int k = 0; k < NumCores; k++) begin
                state_q[k] <= state_d[k];
                tid_q[k]   <= tid_d[k];
                cnt_q[k]   <= cnt_d[k];
                rdata_q[k] <= rdata_d[k];
                if ((state_q[k] == S_IDLE) && cpu_valid_i[k]) begin
                    addr_q[k]  <= cpu_addr_i[32*k +: 32];
                    wdata_q[k] <= cpu_wdata_i[32*k +: 32];
                    wstrb_q[k] <= cpu_wstrb_i[4*k +: 4];
                end
            end
            req_valid_q      <= req_valid_d;
            req_q            <= req_d;
            ptr_q            <= ptr_d;
            err_timeout_q    <= err_timeout_q | tout_set;
            err_bus_q        <= err_bus_q | bus_set;
            err_unexpected_q <= err_unexpected_q | unexpected;
        end
    end

    always_comb begin
        cpu_ready_o = '0;
        cpu_rdata_o = '0;
        for (int k = 0; k < NumCores; k++) begin
            cpu_ready_o[k]          = (state_q[k] == S_DONE);
            cpu_rdata_o[32*k +: 32] = rdata_q[k];
        end
    end

    assign req_valid_o       = req_valid_q;
    assign req_addr_o        = req_q.addr;
    assign req_wdata_o       = req_q.wdata;
    assign req_be_o          = req_q.be;
    assign req_store_o       = req_q.store;
    assign req_uncacheable_o = req_q.uncacheable;
    assign req_sid_o         = req_q.sid;
    assign req_tid_o         = req_q.tid;
    assign err_timeout_o     = err_timeout_q;
    assign err_bus_o         = err_bus_q;
    assign err_unexpected_o  = err_unexpected_q;

endmodule
